// File: rtl/brute_candidate_gen.sv
// Brute-force candidate generator: odometer over a fixed charset, shortest candidates first.
// Latency: first candidate 1 cycle after start; next candidate 1 cycle after each transfer (1/cycle).
// Backpressure: candidate is held stable while cand_valid && !cand_ready; found ends the run at once.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start               one-cycle pulse; begins a run from IDLE or DONE (ignored in RUN)
//   found               one-cycle pulse from compare stage; ends the run (RUN only)
//   cand_ready          downstream can accept the presented candidate
//   cand_valid          cand_data/cand_len hold a valid candidate
//   cand_data           candidate bytes, lane 0 in [7:0]; lanes >= cand_len are zero
//   cand_len            candidate length in characters
//   attempt_count       candidates accepted this run
//   busy / done         in RUN / in DONE (done held until next start)
//   done_reason         0 none, 1 found, 2 attempt limit, 3 space exhausted
module brute_candidate_gen #(
  parameter int         MAX_LEN      = 4,
  parameter int         CHARSET_SIZE = 26,
  parameter logic [7:0] CHAR_BASE    = 8'h61,
  parameter int         MAX_ATTEMPTS = 100
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 found,
  input  logic                 cand_ready,
  output logic                 cand_valid,
  output logic [8*MAX_LEN-1:0] cand_data,
  output logic [2:0]           cand_len,
  output logic [31:0]          attempt_count,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           done_reason
);

  localparam int DW = (CHARSET_SIZE > 1) ? $clog2(CHARSET_SIZE) : 1;
  localparam logic [DW-1:0]          TOP_DIGIT  = DW'(CHARSET_SIZE - 1);
  localparam logic [8*MAX_LEN-1:0]   FIRST_DATA = (8*MAX_LEN)'(CHAR_BASE);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               state;
  logic [DW-1:0]        digit_q  [MAX_LEN];
  logic [DW-1:0]        digit_nx [MAX_LEN];
  logic                 carry;
  logic                 wrap;
  logic [2:0]           len_nx;
  logic [8*MAX_LEN-1:0] data_nx;
  logic                 xfer;
  logic                 at_limit;
  logic                 is_last;

  // Next candidate: increment the odometer from digit 0, carrying up to the
  // current length. A carry out of the top digit means every digit was at the
  // top symbol, so the digits are already all zero and only the length grows.
  always_comb begin
    carry = 1'b1;
    for (int i = 0; i < MAX_LEN; i++) begin
      digit_nx[i] = digit_q[i];
      if (carry && (3'(i) < cand_len)) begin
        if (digit_q[i] == TOP_DIGIT) begin
          digit_nx[i] = '0;
        end else begin
          digit_nx[i] = digit_q[i] + DW'(1);
          carry       = 1'b0;
        end
      end
    end
    wrap   = carry;
    len_nx = wrap ? (cand_len + 3'd1) : cand_len;
    data_nx = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (3'(i) < len_nx) data_nx[8*i +: 8] = CHAR_BASE + 8'(digit_nx[i]);
    end
  end

  assign xfer     = cand_valid && cand_ready;
  assign at_limit = (attempt_count + 32'd1) == 32'(MAX_ATTEMPTS);
  // Carry out of a full-length candidate: the whole space has been produced.
  assign is_last  = (cand_len == 3'(MAX_LEN)) && wrap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      cand_valid    <= 1'b0;
      cand_data     <= '0;
      cand_len      <= 3'd1;
      attempt_count <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      done_reason   <= 2'd0;
      for (int i = 0; i < MAX_LEN; i++) digit_q[i] <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state         <= S_RUN;
            cand_valid    <= 1'b1;
            cand_data     <= FIRST_DATA;
            cand_len      <= 3'd1;
            attempt_count <= '0;
            busy          <= 1'b1;
            done          <= 1'b0;
            done_reason   <= 2'd0;
            for (int i = 0; i < MAX_LEN; i++) digit_q[i] <= '0;
          end
        end
        S_RUN: begin
          if (xfer) attempt_count <= attempt_count + 32'd1;
          if (found) begin
            // A simultaneous transfer is counted above but not advanced.
            state       <= S_DONE;
            cand_valid  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            done_reason <= 2'd1;
          end else if (xfer) begin
            if (at_limit || is_last) begin
              state       <= S_DONE;
              cand_valid  <= 1'b0;
              busy        <= 1'b0;
              done        <= 1'b1;
              done_reason <= at_limit ? 2'd2 : 2'd3;
            end else begin
              cand_data <= data_nx;
              cand_len  <= len_nx;
              for (int i = 0; i < MAX_LEN; i++) digit_q[i] <= digit_nx[i];
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_brute_candidate_gen.sv
// Testbench for brute_candidate_gen: default instance plus a 3-symbol, 2-char instance.
// Inputs driven and outputs sampled 1 time unit after the rising clock edge.
// Summary line reports passed/total comparisons.
module tb_brute_candidate_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, found, cand_ready;
  logic        cand_valid, busy, done;
  logic [31:0] cand_data;
  logic [2:0]  cand_len;
  logic [31:0] attempt_count;
  logic [1:0]  done_reason;

  logic        start_s, found_s, ready_s;
  logic        valid_s, busy_s, done_s;
  logic [15:0] data_s;
  logic [2:0]  len_s;
  logic [31:0] count_s;
  logic [1:0]  reason_s;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  brute_candidate_gen dut (
    .clk(clk), .reset(reset), .start(start), .found(found), .cand_ready(cand_ready),
    .cand_valid(cand_valid), .cand_data(cand_data), .cand_len(cand_len),
    .attempt_count(attempt_count), .busy(busy), .done(done), .done_reason(done_reason)
  );

  brute_candidate_gen #(.MAX_LEN(2), .CHARSET_SIZE(3), .CHAR_BASE(8'h61), .MAX_ATTEMPTS(100)) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .found(found_s), .cand_ready(ready_s),
    .cand_valid(valid_s), .cand_data(data_s), .cand_len(len_s),
    .attempt_count(count_s), .busy(busy_s), .done(done_s), .done_reason(reason_s)
  );

  // Expected {len, data} of the k-th (0-based) candidate for the default charset a..z.
  function automatic logic [34:0] exp_cand(input int k);
    int j;
    if (k < 26) return {3'd1, 24'h0, 8'(8'h61 + k)};
    j = k - 26;
    return {3'd2, 16'h0, 8'(8'h61 + j / 26), 8'(8'h61 + j % 26)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic reset_pulse();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 0; found = 0; cand_ready = 0;
    start_s = 0; found_s = 0; ready_s = 0;
    #3;
    total++;
    if ({cand_valid, cand_data, cand_len, attempt_count, busy, done, done_reason} !==
        {1'b0, 32'h0, 3'd1, 32'd0, 1'b0, 1'b0, 2'd0})
      $display("FAIL reset_default: got v=%b d=%h l=%0d c=%0d b=%b dn=%b r=%0d", cand_valid,
               cand_data, cand_len, attempt_count, busy, done, done_reason);
    else passed++;
    total++;
    if ({valid_s, data_s, len_s, count_s, busy_s, done_s, reason_s} !==
        {1'b0, 16'h0, 3'd1, 32'd0, 1'b0, 1'b0, 2'd0})
      $display("FAIL reset_small: got v=%b d=%h l=%0d c=%0d", valid_s, data_s, len_s, count_s);
    else passed++;
    @(negedge clk) reset = 1'b0;
    step();
  endtask

  task automatic test_space_exhausted();
    logic [15:0] seq [12] = '{16'h0061, 16'h0062, 16'h0063, 16'h6161, 16'h6162, 16'h6163,
                              16'h6261, 16'h6262, 16'h6263, 16'h6361, 16'h6362, 16'h6363};
    ready_s = 1'b1;
    start_s = 1'b1;
    step();
    start_s = 1'b0;
    for (int k = 0; k < 12; k++) begin
      total++;
      if ({valid_s, data_s, len_s} !== {1'b1, seq[k], (k < 3) ? 3'd1 : 3'd2})
        $display("FAIL small_seq[%0d]: got v=%b d=%h l=%0d want d=%h", k, valid_s, data_s,
                 len_s, seq[k]);
      else passed++;
      step();
    end
    total++;
    if ({done_s, reason_s, count_s, valid_s, busy_s} !== {1'b1, 2'd3, 32'd12, 1'b0, 1'b0})
      $display("FAIL small_exhausted: got done=%b reason=%0d count=%0d valid=%b busy=%b",
               done_s, reason_s, count_s, valid_s, busy_s);
    else passed++;
    ready_s = 1'b0;
  endtask

  task automatic test_attempt_limit();
    logic [34:0] e;
    cand_ready = 1'b1;
    pulse_start();
    for (int k = 0; k < 100; k++) begin
      e = exp_cand(k);
      total++;
      if ({cand_valid, cand_len, cand_data, attempt_count} !== {1'b1, e, 32'(k)})
        $display("FAIL limit_seq[%0d]: got v=%b l=%0d d=%h c=%0d want %h", k, cand_valid,
                 cand_len, cand_data, attempt_count, e);
      else passed++;
      if (k == 26) begin
        total++;
        if ({cand_len, cand_data} !== {3'd2, 32'h0000_6161})
          $display("FAIL limit_aa: got l=%0d d=%h want l=2 d=00006161", cand_len, cand_data);
        else passed++;
      end
      step();
    end
    total++;
    if ({cand_valid, busy, done, done_reason, attempt_count, cand_data} !==
        {1'b0, 1'b0, 1'b1, 2'd2, 32'd100, 32'h0000_6376})
      $display("FAIL limit_done: got v=%b b=%b dn=%b r=%0d c=%0d d=%h", cand_valid, busy,
               done, done_reason, attempt_count, cand_data);
    else passed++;
  endtask

  task automatic test_backpressure();
    logic [34:0] e;
    logic [31:0] prev_data;
    logic        prev_hold;
    logic        r;
    int          k;
    k = 0;
    prev_hold = 1'b0;
    prev_data = '0;
    cand_ready = 1'b0;
    pulse_start();
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if (done) break;
      if (prev_hold) begin
        total++;
        if ({cand_valid, cand_data} !== {1'b1, prev_data})
          $display("FAIL bp_hold[%0d]: got v=%b d=%h want d=%h", cyc, cand_valid, cand_data,
                   prev_data);
        else passed++;
      end
      r = 1'($urandom_range(0, 1));
      cand_ready = r;
      if (cand_valid && r) begin
        e = exp_cand(k);
        total++;
        if ({cand_len, cand_data} !== e)
          $display("FAIL bp_seq[%0d]: got l=%0d d=%h want %h", k, cand_len, cand_data, e);
        else passed++;
        k++;
      end
      prev_hold = cand_valid && !r;
      prev_data = cand_data;
      step();
    end
    total++;
    if ({done, done_reason, attempt_count} !== {1'b1, 2'd2, 32'd100})
      $display("FAIL bp_done: got done=%b reason=%0d count=%0d", done, done_reason,
               attempt_count);
    else passed++;
    cand_ready = 1'b1;
  endtask

  task automatic test_found();
    cand_ready = 1'b1;
    pulse_start();
    for (int k = 0; k < 4; k++) step();
    total++;
    if ({cand_valid, cand_data} !== {1'b1, 32'h0000_0065})
      $display("FAIL found_pre: got v=%b d=%h want d=00000065", cand_valid, cand_data);
    else passed++;
    found = 1'b1;
    step();
    found = 1'b0;
    total++;
    if ({cand_valid, busy, done, done_reason, attempt_count, cand_data} !==
        {1'b0, 1'b0, 1'b1, 2'd1, 32'd5, 32'h0000_0065})
      $display("FAIL found_done: got v=%b b=%b dn=%b r=%0d c=%0d d=%h", cand_valid, busy,
               done, done_reason, attempt_count, cand_data);
    else passed++;
    step();
    total++;
    if ({cand_valid, done, done_reason, attempt_count} !== {1'b0, 1'b1, 2'd1, 32'd5})
      $display("FAIL found_hold: got v=%b dn=%b r=%0d c=%0d", cand_valid, done, done_reason,
               attempt_count);
    else passed++;
    pulse_start();
    total++;
    if ({cand_valid, cand_data, cand_len, attempt_count, done, done_reason, busy} !==
        {1'b1, 32'h0000_0061, 3'd1, 32'd0, 1'b0, 2'd0, 1'b1})
      $display("FAIL found_restart: got v=%b d=%h l=%0d c=%0d dn=%b r=%0d", cand_valid,
               cand_data, cand_len, attempt_count, done, done_reason);
    else passed++;
  endtask

  task automatic test_async_reset();
    cand_ready = 1'b1;
    for (int k = 0; k < 7; k++) step();
    total++;
    if ({cand_data, attempt_count} !== {32'h0000_0068, 32'd7})
      $display("FAIL arst_pre: got d=%h c=%0d want d=00000068 c=7", cand_data, attempt_count);
    else passed++;
    #3 reset = 1'b1;
    #1;
    total++;
    if ({cand_valid, cand_data, cand_len, attempt_count, busy, done, done_reason} !==
        {1'b0, 32'h0, 3'd1, 32'd0, 1'b0, 1'b0, 2'd0})
      $display("FAIL arst_immediate: got v=%b d=%h l=%0d c=%0d b=%b", cand_valid, cand_data,
               cand_len, attempt_count, busy);
    else passed++;
    @(negedge clk) reset = 1'b0;
    step();
    total++;
    if ({cand_valid, busy} !== 2'b00)
      $display("FAIL arst_idle: got v=%b b=%b want 0 0", cand_valid, busy);
    else passed++;
    pulse_start();
    total++;
    if ({cand_valid, cand_data, attempt_count} !== {1'b1, 32'h0000_0061, 32'd0})
      $display("FAIL arst_restart: got v=%b d=%h c=%0d", cand_valid, cand_data, attempt_count);
    else passed++;
  endtask

  task automatic test_ignored_controls();
    reset_pulse();
    found = 1'b1;
    step();
    found = 1'b0;
    total++;
    if ({busy, done, cand_valid, done_reason} !== {1'b0, 1'b0, 1'b0, 2'd0})
      $display("FAIL idle_found: got b=%b dn=%b v=%b r=%0d", busy, done, cand_valid,
               done_reason);
    else passed++;
    cand_ready = 1'b1;
    pulse_start();
    for (int k = 0; k < 3; k++) step();
    start = 1'b1;
    step();
    start = 1'b0;
    total++;
    if ({busy, cand_valid, cand_data, attempt_count} !== {1'b1, 1'b1, 32'h0000_0065, 32'd4})
      $display("FAIL run_start: got b=%b v=%b d=%h c=%0d want d=00000065 c=4", busy,
               cand_valid, cand_data, attempt_count);
    else passed++;
    step();
    total++;
    if ({cand_data, attempt_count} !== {32'h0000_0066, 32'd5})
      $display("FAIL run_continue: got d=%h c=%0d want d=00000066 c=5", cand_data,
               attempt_count);
    else passed++;
    start = 1'b1;
    found = 1'b1;
    step();
    start = 1'b0;
    found = 1'b0;
    total++;
    if ({cand_valid, done, done_reason, attempt_count} !== {1'b0, 1'b1, 2'd1, 32'd6})
      $display("FAIL start_found: got v=%b dn=%b r=%0d c=%0d", cand_valid, done, done_reason,
               attempt_count);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_space_exhausted();
    test_attempt_limit();
    test_backpressure();
    test_found();
    test_async_reset();
    test_ignored_controls();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/brute_candidate_gen.md
Name: brute_candidate_gen

Overview:
Brute-force password candidate generator for the cracker top level. It runs after the dictionary pass is exhausted and produces an ordered stream of fixed-charset candidates, shortest first. Candidates go to the hash/compare stage over a valid/ready handshake. The generator stops on an external match, when the attempt budget is reached, or when the candidate space is exhausted, and reports which of these ended the run.

Parameters:
MAX_LEN, 4, maximum candidate length in characters (1..7)
CHARSET_SIZE, 26, number of symbols in the charset (2..256)
CHAR_BASE, 8'h61, byte code of symbol index 0 ('a'); symbol i = CHAR_BASE + i
MAX_ATTEMPTS, 100, candidates accepted before giving up (≥1)

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a run from IDLE or DONE, ignored in RUN
found  in  1  one-cycle pulse from compare stage; ends the run
cand_ready  in  1  downstream can accept a candidate
cand_valid  out  1  cand_data/cand_len hold a valid candidate
cand_data  out  8*MAX_LEN  candidate bytes; lane 0 = bits[7:0]; lanes ≥ cand_len are 8'h00
cand_len  out  3  current candidate length (1..MAX_LEN)
attempt_count  out  32  candidates accepted this run
busy  out  1  high in RUN
done  out  1  high in DONE, held until next start
done_reason  out  2  0 none, 1 found, 2 attempt limit, 3 space exhausted

Behaviour:
- Reset (asynchronous, any state): FSM goes to IDLE. cand_valid=0, cand_data=0, cand_len=1, attempt_count=0, busy=0, done=0, done_reason=0, all digit indices 0.
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE + start: the next edge enters RUN.
  - Digits are cleared and cand_len is set to 1.
  - attempt_count, done and done_reason are cleared.
  - cand_valid=1 with candidate CHAR_BASE (1-cycle latency from start).
- Handshake: a transfer occurs when cand_valid && cand_ready at a clk edge.
  - cand_data and cand_len are held stable while cand_valid=1 and cand_ready=0.
  - cand_valid never drops in RUN without a transfer, except on found.
- Advance on transfer (odometer):
  - Digit 0 (lane 0) is the least significant digit.
  - Increment digit 0; if it equals CHARSET_SIZE, set it to 0 and carry into the next digit, up to cand_len-1.
  - If the carry leaves the top digit: cand_len+1 and all digits 0 (e.g. "cc" -> "aaa").
  - The next candidate is presented in the cycle after the transfer, so full throughput is 1 candidate/cycle.
- attempt_count increments by 1 on every transfer and never wraps; it stops at MAX_ATTEMPTS.
- Termination, evaluated on the transfer edge:
  - If attempt_count+1 == MAX_ATTEMPTS: go to DONE with reason 2.
  - Else if the transferred candidate was the last one (cand_len==MAX_LEN, all digits CHARSET_SIZE-1): go to DONE with reason 3.
  - If both conditions hold on the same edge, reason 2 wins.
- found in RUN: the next edge goes to DONE with reason 1 and cand_valid=0.
  - found has priority over a simultaneous transfer: the transfer is still counted, but no advance is presented.
  - found outside RUN is ignored.
- DONE: cand_valid=0, busy=0, done=1. cand_data/cand_len keep the last presented candidate for debug.
- start and found on the same edge in RUN: found wins; start is ignored.
- Reset mid-run: immediate return to IDLE; no partial candidate remains valid.
- Widths:
  - Digit indices are ceil(log2(CHARSET_SIZE)) bits.
  - The byte is CHAR_BASE + index, truncated to 8 bits; the parameter range must keep it ≤ 8'hFF.

Test Plan:
1. CHARSET_SIZE=3, MAX_LEN=2, MAX_ATTEMPTS=100, cand_ready=1, start -> accepted sequence a,b,c,aa,ba,ca,ab,bb,cb,ac,bc,cc (lane0 first, 12 transfers) -> done=1, done_reason=3, attempt_count=12.
2. Defaults, cand_ready=1, start -> after the 100th transfer: done_reason=2, attempt_count=100, cand_valid=0 next cycle. Transfer 27 carries "aa" with cand_len=2.
3. Defaults, cand_ready toggling 1/0 pseudo-randomly -> cand_data stable whenever valid&&!ready. Accepted sequence is identical to scenario 2.
4. Defaults, found pulsed on the same edge as transfer 5 ("e") -> next cycle done_reason=1, attempt_count=5, cand_valid=0. A later start restarts at "a" with attempt_count=0.
5. Reset asserted asynchronously mid-run (between edges, after 7 transfers) -> outputs at reset values immediately. start after release -> first candidate "a".
6. start pulsed during RUN, and found pulsed in IDLE -> both ignored: no restart, no state change, sequence continues unchanged.
